pulse_width_decoder: RTL and testbench
======================================

Name: pulse_width_decoder

Overview:
- Receive end of the pulse interface: measures the high time of each pulse on a single-bit line, in clock cycles.
- Delivers each measured width as a word on a valid/ready output with a single-entry holding register.
- Flags runt pulses, stuck-high lines and output overruns through sticky status bits.
- Sits between a pulse-producing line (pulse generator, external pin) and downstream logic that consumes widths.

Parameters:
- WIDTH_BITS, 8, width of the cycle counter and of width_out.
- MIN_WIDTH, 1, shortest accepted pulse in cycles; must be >= 1.
- MAX_WIDTH, 200, longest accepted pulse in cycles; must be < 2**WIDTH_BITS.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- pulse_in  in  1  pulse line, sampled each posedge.
- clear  in  1  clears the sticky flags runt, timeout and overrun.
- width_out  out  WIDTH_BITS  measured high width in cycles.
- width_valid  out  1  width_out holds an undelivered value.
- width_ready  in  1  consumer accepts width_out when valid && ready.
- runt  out  1  sticky; a pulse shorter than MIN_WIDTH was discarded.
- timeout  out  1  sticky; a pulse exceeded MAX_WIDTH.
- overrun  out  1  sticky; a width was dropped because the holding register was full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cnt=0, width_out=0, width_valid=0, runt/timeout/overrun=0, busy=0, prev sample register=1.
  - prev=1 means a line already high at reset release is ignored until it has been seen low.
- Edge detect: rise = s & !prev, where s is the sampled line (pulse_in, or the synchronizer output). prev <= s every cycle.
- State IDLE:
  - On rise: cnt <= 1, go to MEASURE.
- State MEASURE:
  - s==1 and cnt < MAX_WIDTH: cnt <= cnt+1.
  - s==1 and cnt == MAX_WIDTH: timeout <= 1, go to STUCK. A pulse of exactly MAX_WIDTH is therefore legal; MAX_WIDTH+1 trips timeout.
  - s==0 and cnt < MIN_WIDTH: runt <= 1, no delivery, go to IDLE.
  - s==0 and cnt >= MIN_WIDTH: deliver cnt, go to IDLE.
- State STUCK:
  - Wait for s==0, then go to IDLE. Nothing is delivered.
- Counter rules: cnt is WIDTH_BITS wide, unsigned, never wraps (bounded by MAX_WIDTH).
- Latency: pulse high for N sampled edges t0..t0+N-1, low at t0+N → width_out=N, width_valid=1 from edge t0+N (one cycle after the line is seen low).
- Back-to-back pulses: a single low cycle between pulses is enough; the next rise is detected from IDLE.
- Delivery into the holding register:
  - Register empty, or handshake (valid && ready) in the same cycle: load cnt, width_valid=1.
  - Register full and no handshake: keep the old value, overrun <= 1.
- Handshake with no new delivery: width_valid <= 0. width_out holds its last value.
- Sticky flags: clear and a new set in the same cycle → the flag ends up set (set wins).
- Reset mid-pulse: all state discarded; prev=1 forces the rest of the current pulse to be ignored.

Optional Feature:
- Macro PULSE_WIDTH_DECODER_SYNC_EN.
- Defined: pulse_in passes through a 2-flop synchronizer (both flops reset to 1) before edge detection. Every latency above grows by 2 cycles. Pulse_in may be asynchronous.
- Undefined: s = pulse_in directly. Pulse_in must be synchronous to clock.

Decomposition:
- Package pulse_width_decoder_pkg:
  - state enum typedef (IDLE, MEASURE, STUCK);
  - default constants for WIDTH_BITS, MIN_WIDTH and MAX_WIDTH.
- Sub-module pulse_input_sync: 2-flop synchronizer with parameterised reset value; instantiated only when PULSE_WIDTH_DECODER_SYNC_EN is defined.
- Everything else in one module.

Test Plan:
- Defaults, ready=1, pulse 5 cycles high → width_out=5, width_valid high one cycle after the first low sample, all flags 0.
- MIN_WIDTH=3, pulse 2 cycles → no valid, runt=1; pulse clear → runt=0; clear asserted in the same cycle as a new runt → runt=1.
- Line held high 250 cycles → timeout=1 on the 201st high sample, no valid, busy until the line goes low; then a 200-cycle pulse → width_out=200, timeout stays 1.
- ready=0, pulses of 4 then 7 → width_out stays 4, overrun=1; raise ready → 4 consumed, width_valid=0.
- ready=1 exactly on the edge where the 7 is delivered while the 4 is pending → 4 consumed, width_out=7, width_valid stays 1, overrun=0.
- reset during a pulse at cnt=10 → all outputs 0; the remaining high time is ignored; next 3-cycle pulse → width_out=3.

Source files
------------

// File: rtl/pulse_width_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_decoder_pkg
// Description : Shared types and default constants for the pulse width
//               decoder (FSM state encoding, counter width and width limits).
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_width_decoder_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

    // Default configuration
    localparam int c_DEF_WIDTH_BITS = 8;
    localparam int c_DEF_MIN_WIDTH  = 1;
    localparam int c_DEF_MAX_WIDTH  = 200;

endpackage : pulse_width_decoder_pkg
`default_nettype wire

// File: rtl/pulse_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : pulse_input_sync
// Description : Two-flop synchronizer for a single-bit asynchronous input,
//               with a parameterised reset value for both stages.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_input_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops to resolve metastability on the raw line
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : pulse_input_sync
`default_nettype wire

// File: rtl/pulse_width_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pulse_width_decoder
// Description : Measures the high time of each pulse on a single-bit line in
//               clock cycles and delivers it through a single-entry
//               valid/ready holding register. Sticky flags report runt
//               pulses, stuck-high lines and dropped widths.
//               Build option: define PULSE_WIDTH_DECODER_SYNC_EN to pass
//               pulse_in through a 2-flop synchronizer (+2 cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_decoder
    import pulse_width_decoder_pkg::*;
#(
    parameter int WIDTH_BITS = c_DEF_WIDTH_BITS,
    parameter int MIN_WIDTH  = c_DEF_MIN_WIDTH,
    parameter int MAX_WIDTH  = c_DEF_MAX_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pulse_in,
    input  logic                  clear,
    output logic [WIDTH_BITS-1:0] width_out,
    output logic                  width_valid,
    input  logic                  width_ready,
    output logic                  runt,
    output logic                  timeout,
    output logic                  overrun,
    output logic                  busy
);

    localparam logic [WIDTH_BITS-1:0] c_MIN = WIDTH_BITS'(MIN_WIDTH);
    localparam logic [WIDTH_BITS-1:0] c_MAX = WIDTH_BITS'(MAX_WIDTH);
    localparam logic [WIDTH_BITS-1:0] c_ONE = WIDTH_BITS'(1);

    logic                  w_s;
    logic                  w_rise;
    logic                  w_handshake;
    logic                  r_prev;
    state_t                r_state;
    state_t                w_next_state;
    logic [WIDTH_BITS-1:0] r_cnt;
    logic [WIDTH_BITS-1:0] w_cnt_next;
    logic                  w_deliver;
    logic                  w_set_runt;
    logic                  w_set_timeout;
    logic [WIDTH_BITS-1:0] r_width;
    logic                  r_valid;
    logic                  r_runt;
    logic                  r_timeout;
    logic                  r_overrun;

`ifdef PULSE_WIDTH_DECODER_SYNC_EN
    pulse_input_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (pulse_in),
        .o_sync  (w_s)
    );
`else
    assign w_s = pulse_in;
`endif

    // Previous sample; resets high so a line already high is ignored
    // until it has been seen low at least once
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_rise      = w_s & ~r_prev;
    assign w_handshake = r_valid & width_ready;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, counter update and delivery/flag requests
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = r_cnt;
        w_deliver     = 1'b0;
        w_set_runt    = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_cnt_next   = c_ONE;
                    w_next_state = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_s) begin
                    // A pulse of exactly MAX_WIDTH is legal; one more trips
                    if (r_cnt < c_MAX) begin
                        w_cnt_next = r_cnt + c_ONE;
                    end else begin
                        w_set_timeout = 1'b1;
                        w_next_state  = ST_STUCK;
                    end
                end else begin
                    if (r_cnt < c_MIN) begin
                        w_set_runt = 1'b1;
                    end else begin
                        w_deliver = 1'b1;
                    end
                    w_next_state = ST_IDLE;
                end
            end
            ST_STUCK: begin
                if (!w_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Cycle counter, bounded by MAX_WIDTH so it never wraps
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Single-entry holding register; a handshake frees the slot in the
    // same cycle a new width arrives
    always_ff @(posedge clock) begin
        if (reset) begin
            r_width <= '0;
            r_valid <= 1'b0;
        end else if (w_deliver) begin
            if (!r_valid || w_handshake) begin
                r_width <= r_cnt;
                r_valid <= 1'b1;
            end
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky status flags; a new set wins over a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_runt    <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_set_runt) begin
                r_runt <= 1'b1;
            end else if (clear) begin
                r_runt <= 1'b0;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end else if (clear) begin
                r_timeout <= 1'b0;
            end
            if (w_deliver && r_valid && !w_handshake) begin
                r_overrun <= 1'b1;
            end else if (clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign width_out   = r_width;
    assign width_valid = r_valid;
    assign runt        = r_runt;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;
    assign busy        = (r_state != ST_IDLE);

endmodule : pulse_width_decoder
`default_nettype wire

// File: tb/tb_pulse_width_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_width_decoder
// Description : Self-checking bench for pulse_width_decoder. Directed
//               scenarios plus randomized pulse trains checked against a
//               run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_width_decoder;

    localparam int c_MIN = 3;
    localparam int c_MAX = 200;
`ifdef PULSE_WIDTH_DECODER_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic       clear;
    logic       width_ready;
    logic [7:0] width_out;
    logic       width_valid;
    logic       runt;
    logic       timeout;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: line delay, run length of the current armed pulse
    logic       m_d1, m_d2;
    bit         m_armed;
    int         m_run;
    logic [7:0] m_width;
    bit         m_valid, m_runt, m_timeout, m_overrun;

    pulse_width_decoder #(
        .WIDTH_BITS (8),
        .MIN_WIDTH  (c_MIN),
        .MAX_WIDTH  (c_MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .clear       (clear),
        .width_out   (width_out),
        .width_valid (width_valid),
        .width_ready (width_ready),
        .runt        (runt),
        .timeout     (timeout),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // One clock: drive inputs, advance the model, settle past the edge
    task automatic step(input logic p, input logic rdy, input logic clr, input logic rst);
        bit s, set_r, set_t, set_o, deliver, hs;
        int len;
        pulse_in    = p;
        width_ready = rdy;
        clear       = clr;
        reset       = rst;
        @(posedge clock);
        if (rst) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_armed = 0; m_run = 0;
            m_width = 8'd0; m_valid = 0; m_runt = 0; m_timeout = 0; m_overrun = 0;
        end else begin
            if (c_LAT > 0) begin
                s = m_d2; m_d2 = m_d1; m_d1 = p;
            end else begin
                s = p;
            end
            set_r = 0; set_t = 0; set_o = 0; deliver = 0; len = 0;
            hs = m_valid && rdy;
            if (s) begin
                if (m_armed) begin
                    m_run++;
                    if (m_run == c_MAX + 1) set_t = 1;
                end
            end else begin
                if (m_armed && m_run > 0) begin
                    if (m_run < c_MIN) set_r = 1;
                    else if (m_run <= c_MAX) begin deliver = 1; len = m_run; end
                end
                m_run = 0;
                m_armed = 1;
            end
            if (deliver) begin
                if (!m_valid || hs) begin m_width = len[7:0]; m_valid = 1; end
                else set_o = 1;
            end else if (hs) begin
                m_valid = 0;
            end
            m_runt    = set_r ? 1'b1 : (clr ? 1'b0 : m_runt);
            m_timeout = set_t ? 1'b1 : (clr ? 1'b0 : m_timeout);
            m_overrun = set_o ? 1'b1 : (clr ? 1'b0 : m_overrun);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd0) begin n_errors++; $display("FAIL reset_width_out: got %0d expected 0", width_out); end
        n_checks++; if (width_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", width_valid); end
        n_checks++; if ({runt, timeout, overrun} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b expected 000", {runt, timeout, overrun}); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        repeat (2 + c_LAT) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_valid !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL basic_pre: got valid=%b busy=%b expected valid=0 busy=1", width_valid, busy); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd5 || width_valid !== 1'b1) begin n_errors++; $display("FAIL basic_width: got %0d/%b expected 5/1", width_out, width_valid); end
        n_checks++; if ({runt, timeout, overrun, busy} !== 4'b0000) begin n_errors++; $display("FAIL basic_flags: got %b expected 0000", {runt, timeout, overrun, busy}); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_valid !== 1'b0 || width_out !== 8'd5) begin n_errors++; $display("FAIL basic_consume: got %0d/%b expected 5/0", width_out, width_valid); end
    endtask

    task automatic test_runt();
        repeat (2 + c_LAT) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (runt !== 1'b1 || width_valid !== 1'b0) begin n_errors++; $display("FAIL runt_set: got runt=%b valid=%b expected 1/0", runt, width_valid); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (runt !== 1'b0) begin n_errors++; $display("FAIL runt_clear: got %b expected 0", runt); end
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (runt !== 1'b1) begin n_errors++; $display("FAIL runt_set_wins: got %b expected 1", runt); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd3 || width_valid !== 1'b1 || runt !== 1'b0) begin n_errors++; $display("FAIL runt_min_ok: got %0d/%b runt=%b expected 3/1 runt=0", width_out, width_valid, runt); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        repeat (2 + c_LAT) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (c_MAX + c_LAT) step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL timeout_at_max: got timeout=%b busy=%b expected 0/1", timeout, busy); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_at_max_plus1: got %b expected 1", timeout); end
        repeat (49) step(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b1 || width_valid !== 1'b0) begin n_errors++; $display("FAIL timeout_stuck: got busy=%b valid=%b expected 1/0", busy, width_valid); end
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b0 || width_valid !== 1'b0) begin n_errors++; $display("FAIL timeout_release: got busy=%b valid=%b expected 0/0", busy, width_valid); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (c_MAX) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd200 || width_valid !== 1'b1 || timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_max_pulse: got %0d/%b timeout=%b expected 200/1 timeout=1", width_out, width_valid, timeout); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_clear: got %b expected 0", timeout); end
    endtask

    task automatic test_overrun();
        repeat (2 + c_LAT) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd4 || width_valid !== 1'b1 || overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_hold: got %0d/%b overrun=%b expected 4/1 overrun=1", width_out, width_valid, overrun); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd4 || width_valid !== 1'b0) begin n_errors++; $display("FAIL overrun_drain: got %0d/%b expected 4/0", width_out, width_valid); end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_back_to_back();
        repeat (2 + c_LAT) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (c_LAT) step(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd4 || width_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_first: got %0d/%b expected 4/1", width_out, width_valid); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd7 || width_valid !== 1'b1 || overrun !== 1'b0) begin n_errors++; $display("FAIL b2b_swap: got %0d/%b overrun=%b expected 7/1 overrun=0", width_out, width_valid, overrun); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b expected 0", width_valid); end
    endtask

    task automatic test_reset_mid_pulse();
        repeat (2 + c_LAT) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10 + c_LAT) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({width_out, width_valid, runt, timeout, overrun, busy} !== 13'd0) begin n_errors++; $display("FAIL midreset_outputs: got %0d/%b flags=%b busy=%b expected all 0", width_out, width_valid, {runt, timeout, overrun}, busy); end
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b0 || width_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_ignored: got busy=%b valid=%b expected 0/0", busy, width_valid); end
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (c_LAT + 1) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (width_out !== 8'd3 || width_valid !== 1'b1) begin n_errors++; $display("FAIL midreset_next: got %0d/%b expected 3/1", width_out, width_valid); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int w, gap, n;
        logic rdy, clr, rst;
        bit exp_busy;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            w   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(195, 205)) : int'($urandom_range(1, 12));
            gap = $urandom_range(1, 4);
            for (int k = 0; k < w + gap; k++) begin
                rdy = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 15) == 0);
                rst = ($urandom_range(0, 499) == 0);
                step((k < w), rdy, clr, rst);
                n++;
                exp_busy = (m_run > 0);
                n_checks++;
                if (width_out !== m_width || width_valid !== m_valid || runt !== m_runt ||
                    timeout !== m_timeout || overrun !== m_overrun || busy !== exp_busy) begin
                    n_errors++;
                    $display("FAIL random step %0d: got w=%0d v=%b r=%b t=%b o=%b b=%b expected w=%0d v=%b r=%b t=%b o=%b b=%b",
                             n, width_out, width_valid, runt, timeout, overrun, busy,
                             m_width, m_valid, m_runt, m_timeout, m_overrun, exp_busy);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; pulse_in = 1'b0; clear = 1'b0; width_ready = 1'b1;
        test_reset();
        test_basic();
        test_runt();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_pulse_width_decoder
`default_nettype wire
